// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
//
// One quotient bit is produced per BUSY cycle, MSB first. Signed operands are
// converted to magnitudes on accept and the signs are reapplied on the last
// iteration. While the divide is in flight the pipeline is held through stall_o.
// Quotient and remainder are published on hi_o/lo_o when DONE is entered, and
// DONE produces a one-cycle HI/LO write enable.
//
// Ports:
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   start_i         divide requested by the instruction in E (held while in E)
//   signed_i        1 = DIV (two's complement), 0 = DIVU; sampled with start_i
//   annul_i         cancel current or pending operation (E-stage flush)
//   a_i             dividend (rs)
//   b_i             divisor (rt)
//   stall_o         pipeline hold request (combinational)
//   result_valid_o  one-cycle HI/LO write enable
//   hi_o            remainder
//   lo_o            quotient
module div_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic             signed_i,
    input  logic             annul_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             stall_o,
    output logic             result_valid_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] divisor_q, divisor_d;
    // Holds the remaining dividend bits in its upper part and the quotient bits
    // shifted in from the bottom; after WIDTH shifts it is the whole quotient.
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    // Operand conditioning for accept.
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;

    assign a_neg = signed_i & a_i[WIDTH-1];
    assign b_neg = signed_i & b_i[WIDTH-1];
    // The most negative value maps onto itself, which is the correct magnitude
    // when read as unsigned.
    assign a_abs = a_neg ? (-a_i) : a_i;
    assign b_abs = b_neg ? (-b_i) : b_i;

    // One restoring step.
    logic [WIDTH:0]   rem_shift;
    logic [WIDTH:0]   trial;
    logic             q_bit;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quot_next;

    assign rem_shift = {rem_q, quot_q[WIDTH-1]};
    assign trial     = rem_shift - {1'b0, divisor_q};
    assign q_bit     = (rem_shift >= {1'b0, divisor_q});
    // The kept remainder is always below the divisor, so WIDTH bits suffice.
    assign rem_next  = q_bit ? trial[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    assign quot_next = {quot_q[WIDTH-2:0], q_bit};

    logic unused_trial_msb;
    assign unused_trial_msb = trial[WIDTH];

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        divisor_d      = divisor_q;
        quot_d         = quot_q;
        rem_d          = rem_q;
        q_neg_d        = q_neg_q;
        r_neg_d        = r_neg_q;
        hi_d           = hi_q;
        lo_d           = lo_q;
        stall_o        = 1'b0;
        result_valid_o = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start_i && !annul_i) begin
                    q_neg_d   = a_neg ^ b_neg;
                    r_neg_d   = a_neg;
                    divisor_d = b_abs;
                    quot_d    = a_abs;
                    rem_d     = '0;
                    cnt_d     = '0;
                    if (b_i == '0) begin
                        // Divide by zero completes without holding the pipe.
                        hi_d    = a_i;
                        lo_d    = '1;
                        state_d = StDone;
                    end else begin
                        stall_o = 1'b1;
                        state_d = StBusy;
                    end
                end
            end

            StBusy: begin
                if (annul_i) begin
                    // Flushed: drop the operation, leave all registers untouched.
                    state_d = StIdle;
                end else begin
                    stall_o = 1'b1;
                    rem_d   = rem_next;
                    quot_d  = quot_next;
                    cnt_d   = cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        lo_d    = q_neg_q ? (-quot_next) : quot_next;
                        hi_d    = r_neg_q ? (-rem_next) : rem_next;
                        state_d = StDone;
                    end
                end
            end

            StDone: begin
                // start_i is still high here as the instruction leaves E; ignore it.
                result_valid_o = ~annul_i;
                state_d        = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            rem_q     <= '0;
            q_neg_q   <= 1'b0;
            r_neg_q   <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            divisor_q <= divisor_d;
            quot_q    <= quot_d;
            rem_q     <= rem_d;
            q_neg_q   <= q_neg_d;
            r_neg_q   <= r_neg_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: directed, table-driven bench for div_unit (WIDTH = 32).
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic        signed_i;
    logic        annul_i;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        stall_o;
    logic        result_valid_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int n_checks = 0;
    int n_fail   = 0;

    div_unit #(
        .WIDTH(32)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .signed_i      (signed_i),
        .annul_i       (annul_i),
        .a_i           (a_i),
        .b_i           (b_i),
        .stall_o       (stall_o),
        .result_valid_o(result_valid_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Issues one divide on the next cycle (cycle 0), holds start_i through DONE
    // and returns at the DONE cycle with start_i still high.
    task automatic run_op(input string name, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] elo, input logic [31:0] ehi,
                          input bit annul_done);
        int done_cyc;
        int stall_cnt;
        int valid_cyc;
        int valid_cnt;
        done_cyc  = (b == 32'd0) ? 1 : 33;
        stall_cnt = 0;
        valid_cyc = -1;
        valid_cnt = 0;
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        signed_i = sgn;
        a_i      = a;
        b_i      = b;
        annul_i  = 1'b0;
        for (int cyc = 0; cyc <= done_cyc; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk);
                #1;
            end
            if (cyc == done_cyc && annul_done) annul_i = 1'b1;
            #1;
            if (stall_o) stall_cnt++;
            if (result_valid_o) begin
                valid_cnt++;
                valid_cyc = cyc;
            end
        end
        check({name, " stall cycles"}, 64'(stall_cnt), (b == 32'd0) ? 64'd0 : 64'd33);
        if (annul_done) check({name, " valid count"}, 64'(valid_cnt), 64'd0);
        else check({name, " valid cycle"}, 64'(valid_cyc), 64'(done_cyc));
        check({name, " lo"}, {32'd0, lo_o}, {32'd0, elo});
        check({name, " hi"}, {32'd0, hi_o}, {32'd0, ehi});
    endtask

    // Drops start/annul from the next cycle on and requires a quiet unit.
    task automatic idle_check(input string name, input int ncyc);
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            start_i = 1'b0;
            annul_i = 1'b0;
            #1;
            if (stall_o || result_valid_o) busy_cnt++;
        end
        check({name, " stall/valid while idle"}, 64'(busy_cnt), 64'd0);
    endtask

    initial begin
        vecs[0] = '{"divu 100/7",        1'b0, 32'd100,      32'd7,        32'd14,       32'd2};
        vecs[1] = '{"div -7/2",          1'b1, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{"div 7/-2",          1'b1, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1};
        vecs[3] = '{"div min/-1",        1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        vecs[4] = '{"divu max/1",        1'b0, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0};
        vecs[5] = '{"divu 5/0",          1'b0, 32'd5,        32'd0,        32'hFFFFFFFF, 32'd5};
        vecs[6] = '{"div -5/0",          1'b1, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFF, 32'hFFFFFFFB};
        vecs[7] = '{"div -100/-7",       1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       32'hFFFFFFFE};
        vecs[8] = '{"divu max/16",       1'b0, 32'hFFFFFFFF, 32'd16,       32'h0FFFFFFF, 32'd15};
        vecs[9] = '{"divu 0x8000_0000/max", 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'd0,     32'h80000000};

        rst      = 1'b1;
        start_i  = 1'b0;
        signed_i = 1'b0;
        annul_i  = 1'b0;
        a_i      = '0;
        b_i      = '0;
        #8;
        check("reset hi", {32'd0, hi_o}, 64'd0);
        check("reset lo", {32'd0, lo_o}, 64'd0);
        check("reset valid", {63'd0, result_valid_o}, 64'd0);
        check("reset stall", {63'd0, stall_o}, 64'd0);
        #14;
        rst = 1'b0;

        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, 1'b0);
            // start_i was high in DONE: a restart would show up as stall here.
            idle_check({vecs[i].name, " no restart"}, 2);
        end

        // Annul in DONE: no pulse, but HI/LO already updated.
        run_op("divu 1000/10 annul in done", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 1'b1);
        idle_check("annul in done", 2);

        // Annul in BUSY cycle 10.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        signed_i = 1'b0;
        a_i      = 32'd100;
        b_i      = 32'd7;
        annul_i  = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        #1;
        check("annul busy stall", {63'd0, stall_o}, 64'd0);
        check("annul busy valid", {63'd0, result_valid_o}, 64'd0);
        idle_check("after annul busy", 4);
        check("annul busy lo held", {32'd0, lo_o}, 64'd100);
        check("annul busy hi held", {32'd0, hi_o}, 64'd0);
        run_op("divu 100/7 after annul", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        idle_check("after fresh divide", 1);

        // Asynchronous reset in BUSY cycle 5, between clock edges.
        @(posedge clk);
        #1;
        start_i  = 1'b1;
        signed_i = 1'b1;
        a_i      = 32'hFFFFFFF9;
        b_i      = 32'd2;
        repeat (5) @(posedge clk);
        #4;
        rst     = 1'b1;
        start_i = 1'b0;
        #1;
        check("async reset hi", {32'd0, hi_o}, 64'd0);
        check("async reset lo", {32'd0, lo_o}, 64'd0);
        check("async reset valid", {63'd0, result_valid_o}, 64'd0);
        check("async reset stall", {63'd0, stall_o}, 64'd0);
        #2;
        rst = 1'b0;
        idle_check("after reset release", 40);

        // Back-to-back: second start the cycle after DONE.
        run_op("b2b divu 100/7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        run_op("b2b divu 9/3", 1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        idle_check("after back-to-back", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider in the execute stage. It services DIV/DIVU issued by the decode/execute control path.
- Holds the pipeline through stall_o, which feeds the hazard logic that drives the execute-stage stall and flush controls.
- Returns quotient and remainder to the HI/LO register file with a one-cycle valid pulse.

Parameters:
WIDTH, 32, operand and result width in bits

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
start_i  input  1  divide requested by the instruction in E; held while the instruction sits in E
signed_i  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
annul_i  input  1  cancel the current or pending operation (E-stage flush)
a_i  input  WIDTH  dividend (rs)
b_i  input  WIDTH  divisor (rt)
stall_o  output  1  pipeline hold request
result_valid_o  output  1  one-cycle pulse; HI/LO write enable
hi_o  output  WIDTH  remainder
lo_o  output  WIDTH  quotient

Behaviour:
- Interface fixed: one clock clk; reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE, iteration counter = 0, internal operand/remainder registers = 0.
  - hi_o = 0, lo_o = 0, result_valid_o = 0, stall_o = 0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - Accept when start_i & ~annul_i.
  - On accept, latch |a| and |b| (raw a and b when unsigned), quotient sign = a[W-1]^b[W-1], remainder sign = a[W-1] (signs forced 0 when unsigned).
  - Then go to BUSY with counter = 0.
  - If b_i == 0 on accept: go straight to DONE with lo = all ones, hi = a_i, regardless of signed_i.
- BUSY, one cycle per quotient bit, MSB first:
  - Shift the partial remainder (WIDTH+1 bits) left with the next dividend bit.
  - Trial-subtract the divisor; if non-negative, keep the difference and shift in quotient bit 1, else keep the remainder and shift in 0.
  - After WIDTH iterations (counter == WIDTH-1 on the current cycle), apply sign correction and register hi_o/lo_o, then go to DONE.
  - Sign correction: negate the quotient if its sign is 1; negate the remainder if its sign is 1.
  - Results wrap at WIDTH bits: 0x80000000 / -1 gives lo = 0x80000000, hi = 0.
- DONE:
  - result_valid_o = ~annul_i. Unconditionally return to IDLE next cycle.
  - start_i is ignored in DONE: the completing instruction still asserts start while it leaves E.
- stall_o is combinational: (IDLE & start_i & ~annul_i & b_i != 0) | (BUSY & ~annul_i). It is 0 in DONE.
- Latency:
  - Accept in cycle 0, BUSY in cycles 1..WIDTH, DONE in cycle WIDTH+1.
  - stall_o is high for WIDTH+1 cycles (0..WIDTH). The instruction advances out of E at the end of the DONE cycle.
  - Divide by zero: stall_o stays 0 and DONE follows in cycle 1.
- annul_i:
  - In BUSY: next state IDLE, registers frozen, no valid pulse, hi_o/lo_o keep their previous values.
  - In IDLE: blocks accept.
  - In DONE: suppresses the valid pulse, but hi_o/lo_o already hold the new values.
- hi_o/lo_o change only on entry to DONE and otherwise hold.
- Back-to-back divides:
  - A second DIV entering E the cycle after DONE is accepted from IDLE normally.
  - There is no idle bubble beyond the DONE cycle.
- Reset mid-operation: immediate return to IDLE with the reset values above; no valid pulse.

Test Plan:
- DIVU a=100, b=7, start held: stall_o high cycles 0..32; result_valid_o pulses cycle 33 with lo=14, hi=2; start still high in cycle 33 does not restart.
- DIV a=-7 (0xFFFFFFF9), b=2: lo=0xFFFFFFFD, hi=0xFFFFFFFF at cycle 33; DIV a=7, b=-2 gives lo=0xFFFFFFFD, hi=1.
- Corner cases:
  - DIV a=0x80000000, b=0xFFFFFFFF gives lo=0x80000000, hi=0.
  - DIVU a=0xFFFFFFFF, b=1 gives lo=0xFFFFFFFF, hi=0.
- Divide by zero, a=5, b=0: stall_o never high; valid at cycle 1 with lo=0xFFFFFFFF, hi=5.
- annul_i pulsed at BUSY cycle 10: stall_o drops that cycle, IDLE next, no valid, hi/lo unchanged; a fresh start of 100/7 then completes normally at +33.
- rst asserted asynchronously at BUSY cycle 5 (between clock edges): outputs go to 0 immediately; after release, an idle bench shows stall_o=0 and no valid.
- Two consecutive DIVUs (100/7 then 9/3, start re-asserted the cycle after DONE): valid pulses at cycles 33 and 67 with (14,2) then (3,0).
